// File: rtl/stl_swap_sort_seq.sv
// Sequential in-place bubble sorter: loads N {key,payload} pairs, sorts them with one
// time-shared compare-swap, then streams them out. Optional macro: STL_SORT_EARLY_EXIT_EN.
module stl_swap_sort_seq #(
  parameter int N    = 8,
  parameter int CW   = 4,
  parameter int DW   = 8,
  parameter int MODE = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_vld_i,
  output logic          in_rdy_o,
  input  logic [CW-1:0] in_cmp_i,
  input  logic [DW-1:0] in_sel_i,
  output logic          out_vld_o,
  input  logic          out_rdy_i,
  output logic [CW-1:0] out_cmp_o,
  output logic [DW-1:0] out_sel_o,
  output logic          out_last_o,
  output logic          busy_o
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [IW-1:0] PAIR_LAST = IW'(N - 2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] j;
  logic [IW-1:0] p;
  logic [CW-1:0] key_buf [N];
  logic [DW-1:0] pay_buf [N];

  // Compare-swap decision; strict compare keeps equal keys in arrival order.
  function automatic logic swap_req(input logic [CW-1:0] a, input logic [CW-1:0] b);
    if (MODE == 0) begin
      return a < b;
    end else begin
      return a > b;
    end
  endfunction

  logic [IW-1:0] j_nxt;
  logic          do_swap;
  logic [CW-1:0] lo_key, hi_key;
  logic [DW-1:0] lo_pay, hi_pay;

  always_comb begin
    j_nxt   = j + 1'b1;
    do_swap = swap_req(key_buf[j], key_buf[j_nxt]);
    if (do_swap) begin
      lo_key = key_buf[j_nxt];
      lo_pay = pay_buf[j_nxt];
      hi_key = key_buf[j];
      hi_pay = pay_buf[j];
    end else begin
      lo_key = key_buf[j];
      lo_pay = pay_buf[j];
      hi_key = key_buf[j_nxt];
      hi_pay = pay_buf[j_nxt];
    end
  end

`ifdef STL_SORT_EARLY_EXIT_EN
  logic swapped;
  logic pass_done;
  assign pass_done = (p == PAIR_LAST) || !(swapped || do_swap);
`else
  logic pass_done;
  assign pass_done = (p == PAIR_LAST);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      j      <= '0;
      p      <= '0;
`ifdef STL_SORT_EARLY_EXIT_EN
      swapped <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_vld_i) begin
            if (wr_idx == IDX_LAST) begin
              wr_idx <= '0;
              state  <= SORT;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        SORT: begin
          if (j == PAIR_LAST) begin
            j <= '0;
            if (pass_done) begin
              p     <= '0;
              state <= DRAIN;
            end else begin
              p <= p + 1'b1;
            end
`ifdef STL_SORT_EARLY_EXIT_EN
            swapped <= 1'b0;
`endif
          end else begin
            j <= j_nxt;
`ifdef STL_SORT_EARLY_EXIT_EN
            swapped <= swapped | do_swap;
`endif
          end
        end
        DRAIN: begin
          if (out_rdy_i) begin
            if (rd_idx == IDX_LAST) begin
              rd_idx <= '0;
              state  <= LOAD;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Buffer is deliberately not reset; it is fully rewritten by every frame.
  always_ff @(posedge clk_i) begin
    if (state == LOAD && in_vld_i) begin
      key_buf[wr_idx] <= in_cmp_i;
      pay_buf[wr_idx] <= in_sel_i;
    end else if (state == SORT) begin
      key_buf[j]     <= lo_key;
      pay_buf[j]     <= lo_pay;
      key_buf[j_nxt] <= hi_key;
      pay_buf[j_nxt] <= hi_pay;
    end
  end

  assign in_rdy_o   = (state == LOAD);
  assign out_vld_o  = (state == DRAIN);
  assign busy_o     = (state != LOAD);
  assign out_cmp_o  = out_vld_o ? key_buf[rd_idx] : '0;
  assign out_sel_o  = out_vld_o ? pay_buf[rd_idx] : '0;
  assign out_last_o = out_vld_o && (rd_idx == IDX_LAST);

endmodule

// File: tb/tb_stl_swap_sort_seq.sv
// Directed bench for stl_swap_sort_seq: a MODE 0 and a MODE 1 instance share clock and reset.
module tb_stl_swap_sort_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld   [2];
  logic       in_rdy   [2];
  logic [3:0] in_cmp   [2];
  logic [7:0] in_sel   [2];
  logic       out_vld  [2];
  logic       out_rdy  [2];
  logic [3:0] out_cmp  [2];
  logic [7:0] out_sel  [2];
  logic       out_last [2];
  logic       busy     [2];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef STL_SORT_EARLY_EXIT_EN
  localparam int LAT_FULL  = -1;
  localparam int LAT_CLEAN = 7;
`else
  localparam int LAT_FULL  = 49;
  localparam int LAT_CLEAN = 49;
`endif

  always #5 clk = ~clk;

  stl_swap_sort_seq #(.N(8), .CW(4), .DW(8), .MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .in_vld_i(in_vld[0]), .in_rdy_o(in_rdy[0]), .in_cmp_i(in_cmp[0]), .in_sel_i(in_sel[0]),
    .out_vld_o(out_vld[0]), .out_rdy_i(out_rdy[0]), .out_cmp_o(out_cmp[0]),
    .out_sel_o(out_sel[0]), .out_last_o(out_last[0]), .busy_o(busy[0])
  );

  stl_swap_sort_seq #(.N(8), .CW(4), .DW(8), .MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .in_vld_i(in_vld[1]), .in_rdy_o(in_rdy[1]), .in_cmp_i(in_cmp[1]), .in_sel_i(in_sel[1]),
    .out_vld_o(out_vld[1]), .out_rdy_i(out_rdy[1]), .out_cmp_o(out_cmp[1]),
    .out_sel_o(out_sel[1]), .out_last_o(out_last[1]), .busy_o(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int m, input logic [31:0] keys, input logic [63:0] pays);
    for (int i = 0; i < 8; i++) begin
      int guard;
      @(negedge clk);
      in_vld[m] = 1'b1;
      in_cmp[m] = keys[i*4 +: 4];
      in_sel[m] = pays[i*8 +: 8];
      guard = 0;
      while (!in_rdy[m] && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      check("load_rdy", {63'd0, in_rdy[m]}, 64'd1);
      @(posedge clk);
    end
    #1;
    in_vld[m] = 1'b0;
  endtask

  task automatic wait_sort(input int m, input int exp_lat);
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    @(negedge clk);
    while (!out_vld[m] && guard < 300) begin
      if (busy[m]) cnt++;
      guard++;
      @(negedge clk);
    end
    check("sort_done", {63'd0, out_vld[m]}, 64'd1);
    if (exp_lat >= 0) check("sort_latency", 64'(cnt), 64'(exp_lat));
  endtask

  task automatic drain(input int m, input logic [31:0] keys, input logic [63:0] pays, input bit bp);
    logic [5:0] pat;
    int beat;
    int cyc;
    pat  = 6'b101001;
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 200) begin
      out_rdy[m] = bp ? pat[cyc % 6] : 1'b1;
      in_vld[m]  = 1'b1;
      check("drain_vld",  {63'd0, out_vld[m]}, 64'd1);
      check("drain_busy", {63'd0, busy[m]}, 64'd1);
      check("drain_rdy",  {63'd0, in_rdy[m]}, 64'd0);
      check("drain_key",  {60'd0, out_cmp[m]}, {60'd0, keys[beat*4 +: 4]});
      check("drain_pay",  {56'd0, out_sel[m]}, {56'd0, pays[beat*8 +: 8]});
      check("drain_last", {63'd0, out_last[m]}, {63'd0, (beat == 7)});
      if (out_rdy[m]) beat++;
      cyc++;
      @(negedge clk);
    end
    out_rdy[m] = 1'b0;
    in_vld[m]  = 1'b0;
    check("drain_beats", 64'(beat), 64'd8);
    check("idle_rdy",  {63'd0, in_rdy[m]}, 64'd1);
    check("idle_vld",  {63'd0, out_vld[m]}, 64'd0);
    check("idle_key",  {60'd0, out_cmp[m]}, 64'd0);
    check("idle_last", {63'd0, out_last[m]}, 64'd0);
    check("idle_busy", {63'd0, busy[m]}, 64'd0);
  endtask

  localparam logic [31:0] K_PI   = 32'h62951413;
  localparam logic [63:0] P_ID   = 64'h0706050403020100;
  localparam logic [31:0] K_DSC  = 32'h11234569;
  localparam logic [63:0] P_DSC  = 64'h0301060002040705;
  localparam logic [31:0] K_ASC  = 32'h96543211;
  localparam logic [63:0] P_ASC  = 64'h0507040200060301;
  localparam logic [31:0] K_SRT  = 32'h01234567;
  localparam logic [31:0] K_EQ   = 32'h55555555;

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      in_vld[m]  = 1'b0;
      in_cmp[m]  = 4'd0;
      in_sel[m]  = 8'd0;
      out_rdy[m] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_rdy",  {63'd0, in_rdy[0]}, 64'd1);
    check("rst_vld",  {63'd0, out_vld[0]}, 64'd0);
    check("rst_busy", {63'd0, busy[0]}, 64'd0);
    check("rst_key",  {60'd0, out_cmp[0]}, 64'd0);
    check("rst_pay",  {56'd0, out_sel[0]}, 64'd0);
    check("rst_last", {63'd0, out_last[0]}, 64'd0);
    rst = 1'b0;

    // Descending sort, stable on duplicate 1s.
    load_frame(0, K_PI, P_ID);
    wait_sort(0, LAT_FULL);
    drain(0, K_DSC, P_DSC, 1'b0);

    // Ascending instance, same input.
    load_frame(1, K_PI, P_ID);
    wait_sort(1, LAT_FULL);
    drain(1, K_ASC, P_ASC, 1'b0);

    // Already sorted input with output backpressure.
    load_frame(0, K_SRT, P_ID);
    wait_sort(0, LAT_CLEAN);
    drain(0, K_SRT, P_ID, 1'b1);

    // All keys equal: payload order preserved.
    load_frame(0, K_EQ, P_ID);
    wait_sort(0, LAT_CLEAN);
    drain(0, K_EQ, P_ID, 1'b0);

    // Reset in the middle of SORT, then a clean frame.
    load_frame(0, K_PI, P_ID);
    repeat (20) @(negedge clk);
    check("mid_busy", {63'd0, busy[0]}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_rdy",  {63'd0, in_rdy[0]}, 64'd1);
    check("arst_busy", {63'd0, busy[0]}, 64'd0);
    check("arst_vld",  {63'd0, out_vld[0]}, 64'd0);
    check("arst_key",  {60'd0, out_cmp[0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    load_frame(0, K_PI, P_ID);
    wait_sort(0, LAT_FULL);
    drain(0, K_DSC, P_DSC, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
